// File: rtl/spi_responder_pkg.sv
// rtl/spi_responder_pkg.sv - shared definitions (spi_resp_defs) for the SPI responder
package spi_resp_defs;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;
    localparam int CMD_RW_BIT = 7;

    typedef enum logic [1:0] {
        SR_IDLE  = 2'd0,
        SR_CMD   = 2'd1,
        SR_WDATA = 2'd2,
        SR_RDATA = 2'd3
    } sr_state_e;

endpackage

// File: rtl/spi_responder_if.sv
// rtl/spi_responder_if.sv - register access port between the SPI responder and the register file
interface spi_responder_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr_en;
    logic [DATA_W-1:0] reg_wr_data;
    logic              reg_rd_en;
    logic [DATA_W-1:0] reg_rd_data;

    modport master (
        output reg_addr,
        output reg_wr_en,
        output reg_wr_data,
        output reg_rd_en,
        input  reg_rd_data
    );

    modport slave (
        input  reg_addr,
        input  reg_wr_en,
        input  reg_wr_data,
        input  reg_rd_en,
        output reg_rd_data
    );
endinterface

// File: rtl/spi_responder_sync.sv
// rtl/spi_responder_sync.sv - spi_resp_sync: 3-bit multi-stage synchronizer with edge detect
module spi_resp_sync #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] RESET_VAL   = 3'b000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] i_async,
    output logic [2:0] o_sync,
    output logic [2:0] o_rise,
    output logic [2:0] o_fall
);
    logic [2:0] r_stage [SYNC_STAGES];
    logic [2:0] r_prev;

    // synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= RESET_VAL;
            end
            r_prev <= RESET_VAL;
        end else begin
            r_stage[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_prev <= r_stage[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_stage[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;
endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 target giving register access; SPI_RESP_AUTOINC_EN enables burst address increment
module spi_responder
    import spi_resp_defs::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            spi_sclk,
    input  logic            spi_cs_n,
    input  logic            spi_mosi,
    output logic            spi_miso,
    output logic            spi_miso_oe,
    output logic            busy,
    spi_responder_if.master reg_bus
);
    logic [2:0]        w_sync;
    logic [2:0]        w_rise;
    logic [2:0]        w_fall;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_cs_sync;
    logic              w_cs_rise;
    logic              w_cs_fall;
    logic              w_mosi;
    logic              w_byte_done;
    logic [7:0]        w_byte;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_unused;

    sr_state_e         r_state;
    sr_state_e         w_state_next;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_shift_in;
    logic [DATA_W-1:0] r_shift_out;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_en;
    logic              r_rd_en;
    logic              r_rd_load;
    logic              r_miso;
    logic              r_busy;

    // bit 0 = SCLK, bit 1 = CS_N (idles high), bit 2 = MOSI
    spi_resp_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (3'b010)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async ({spi_mosi, spi_cs_n, spi_sclk}),
        .o_sync  (w_sync),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_sclk_rise = w_rise[0];
    assign w_sclk_fall = w_fall[0];
    assign w_cs_sync   = w_sync[1];
    assign w_cs_rise   = w_rise[1];
    assign w_cs_fall   = w_fall[1];
    assign w_mosi      = w_sync[2];
    assign w_unused    = ^{w_sync[0], w_rise[2], w_fall[2]};

    // the byte as it will look once the bit sampled on this SCLK rise is shifted in
    assign w_byte      = {r_shift_in, w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);

`ifdef SPI_RESP_AUTOINC_EN
    assign w_addr_next = r_addr + 1'b1;
`else
    assign w_addr_next = r_addr;
`endif

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state decode; frame end overrides everything
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SR_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = SR_CMD;
                end
            end
            SR_CMD: begin
                if (w_byte_done) begin
                    w_state_next = w_byte[CMD_RW_BIT] ? SR_RDATA : SR_WDATA;
                end
            end
            default: begin
            end
        endcase
        if (w_cs_rise) begin
            w_state_next = SR_IDLE;
        end
    end

    // shift registers, address, strobes and MISO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_load   <= 1'b0;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_load <= r_rd_en;
            r_busy    <= ~w_cs_sync;

            if (w_cs_rise) begin
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
            end else begin
                if (r_state == SR_IDLE) begin
                    r_bit_cnt <= '0;
                end

                // address moves on only after the write strobe has been seen with the old one
                if (r_wr_en) begin
                    r_addr <= w_addr_next;
                end

                if ((r_state != SR_IDLE) && w_sclk_rise) begin
                    r_shift_in <= w_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        case (r_state)
                            SR_CMD: begin
                                r_addr  <= w_byte[ADDR_W-1:0];
                                r_rd_en <= w_byte[CMD_RW_BIT];
                            end
                            SR_WDATA: begin
                                r_wr_data <= w_byte;
                                r_wr_en   <= 1'b1;
                            end
                            SR_RDATA: begin
                                r_addr  <= w_addr_next;
                                r_rd_en <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                // MISO is only driven from the shift register during read data
                if ((r_state == SR_RDATA) && w_sclk_fall) begin
                    r_miso      <= r_shift_out[DATA_W-1];
                    r_shift_out <= {r_shift_out[DATA_W-2:0], 1'b0};
                end else if (r_state != SR_RDATA) begin
                    r_miso <= 1'b0;
                end

                // read data arrives the cycle after the strobe
                if (r_rd_load) begin
                    r_shift_out <= reg_bus.reg_rd_data;
                end
            end
        end
    end

    assign spi_miso            = r_miso;
    assign spi_miso_oe         = r_busy;
    assign busy                = r_busy;
    assign reg_bus.reg_addr    = r_addr;
    assign reg_bus.reg_wr_en   = r_wr_en;
    assign reg_bus.reg_wr_data = r_wr_data;
    assign reg_bus.reg_rd_en   = r_rd_en;
endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - self-checking bench for spi_responder against a byte-level register model
module tb_spi_responder;

    localparam int HALF = 8;
`ifdef SPI_RESP_AUTOINC_EN
    localparam int INC = 1;
`else
    localparam int INC = 0;
`endif

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic spi_sclk = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic spi_miso_oe;
    logic busy;
    logic load_go  = 1'b0;

    spi_responder_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    spi_responder #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .busy        (busy),
        .reg_bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  dev_mem [128];
    logic [7:0]  ref_mem [128];
    logic [14:0] wq [$];
    logic [6:0]  rq [$];
    logic [7:0]  tx_buf [16];
    logic [7:0]  rx_buf [16];

    // register file seen by the DUT; logs every strobe
    always @(posedge clk) begin
        if (load_go) begin
            for (int i = 0; i < 128; i++) dev_mem[i] <= ref_mem[i];
        end
        if (bus.reg_wr_en) begin
            wq.push_back({bus.reg_addr, bus.reg_wr_data});
            dev_mem[bus.reg_addr] <= bus.reg_wr_data;
        end
        if (bus.reg_rd_en) begin
            rq.push_back(bus.reg_addr);
            bus.reg_rd_data <= dev_mem[bus.reg_addr];
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic spi_frame(input int nbits, input bit end_frame);
        for (int i = 0; i < 16; i++) rx_buf[i] = 8'h00;
        spi_cs_n = 1'b0;
        wait_clk(HALF);
        for (int b = 0; b < nbits; b++) begin
            int by;
            int bi;
            by = b / 8;
            bi = 7 - (b % 8);
            spi_mosi = tx_buf[by][bi];
            wait_clk(HALF);
            rx_buf[by][bi] = spi_miso;
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        if (end_frame) begin
            wait_clk(HALF);
            spi_cs_n = 1'b1;
            spi_mosi = 1'b0;
            wait_clk(4 * HALF);
        end
    endtask

    // data bytes must already be in tx_buf[1..n]
    task automatic do_write(input logic [6:0] a, input int n);
        logic [6:0] ea;
        tx_buf[0] = {1'b0, a};
        wq.delete();
        spi_frame(8 * (n + 1), 1'b1);
        check("wr_count", wq.size(), n);
        for (int k = 0; k < n; k++) begin
            ea = 7'((int'(a) + k * INC) % 128);
            if (k < wq.size()) check("wr_beat", wq[k], {ea, tx_buf[k+1]});
            ref_mem[ea] = tx_buf[k+1];
        end
    endtask

    task automatic do_read(input logic [6:0] a, input int n);
        logic [6:0] ea;
        tx_buf[0] = {1'b1, a};
        for (int k = 1; k <= n; k++) tx_buf[k] = 8'h00;
        rq.delete();
        spi_frame(8 * (n + 1), 1'b1);
        check("rd_cmd_miso", rx_buf[0], 8'h00);
        check("rd_strobes", rq.size(), n + 1);
        if (rq.size() > 0) check("rd_first_addr", rq[0], a);
        for (int k = 0; k < n; k++) begin
            ea = 7'((int'(a) + k * INC) % 128);
            check("rd_byte", rx_buf[k+1], ref_mem[ea]);
        end
    endtask

    initial begin
        logic [6:0] ra;
        int         rn;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'($urandom);
        ref_mem[5] = 8'h3C;

        wait_clk(3);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_oe", spi_miso_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", bus.reg_addr, 7'h00);
        check("rst_wr_en", bus.reg_wr_en, 1'b0);
        check("rst_wr_data", bus.reg_wr_data, 8'h00);
        check("rst_rd_en", bus.reg_rd_en, 1'b0);
        reset_n = 1'b1;
        load_go = 1'b1;
        wait_clk(1);
        load_go = 1'b0;
        wait_clk(4);

        tx_buf[1] = 8'hA5;
        do_write(7'h12, 1);

        do_read(7'h05, 1);

        tx_buf[1] = 8'h11;
        tx_buf[2] = 8'h22;
        tx_buf[3] = 8'h33;
        do_write(7'h7E, 3);
        if (wq.size() == 3) check("burst_third_addr", wq[2][14:8], (INC != 0) ? 7'h00 : 7'h7E);

        // partial data byte: 5 bits then CS_N rises
        tx_buf[0] = 8'h20;
        tx_buf[1] = 8'($urandom);
        wq.delete();
        spi_frame(13, 1'b1);
        check("partial_no_write", wq.size(), 0);
        check("partial_busy", busy, 1'b0);
        tx_buf[1] = 8'($urandom);
        do_write(7'h33, 1);

        // reset mid-read
        tx_buf[0] = 8'h85;
        tx_buf[1] = 8'h00;
        spi_frame(11, 1'b0);
        check("mid_busy", busy, 1'b1);
        check("mid_oe", spi_miso_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rstmid_oe", spi_miso_oe, 1'b0);
        check("rstmid_miso", spi_miso, 1'b0);
        check("rstmid_rd_en", bus.reg_rd_en, 1'b0);
        check("rstmid_wr_en", bus.reg_wr_en, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(8);
        tx_buf[1] = 8'h55;
        do_write(7'h01, 1);

        // randomized frames against the model
        for (int f = 0; f < 8; f++) begin
            ra = 7'($urandom_range(0, 127));
            rn = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                do_read(ra, rn);
            end else begin
                for (int k = 1; k <= rn; k++) tx_buf[k] = 8'($urandom);
                do_write(ra, rn);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
